// File: rtl/result_wr_ctrl.sv
// result_wr_ctrl: upstream feeder for the line-coalescing write buffer.
// Takes a valid/ready stream of DATA_WIDTH-bit results and emits word-addressed
// buffered writes into consecutive memory from a programmable word base address.
// Every completed line and the trailing partial line are flushed with wr_now.
// After the last word the block waits until the write buffer has reported
// one real write per flushed line, then pulses done.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   start                 one-cycle job launch (accepted in IDLE only)
//   base_addr, num_words  first word address, number of words in the job
//   in_data/valid/ready   input result stream (in_ready is combinational)
//   wr_en, wr_now         word write strobe, flush-current-line strobe
//   wr_addr, wr_data      word address, line-wide data (word in [31:0], rest 0)
//   wr_mdata              line tag (index of the line within the job)
//   wr_direct             direct-line write, tied to 0
//   wr_req_almostfull     write-channel backpressure
//   wr_real_valid         one real line write completed
//   busy, done            job active, one-cycle completion pulse
//
// Optional build macro RESULT_WR_PERF_EN adds:
//   perf_cycles   cycles from start acceptance to done inclusive (saturating)
//   stall_cycles  RUN cycles with in_valid=1 and in_ready=0 (saturating)
module result_wr_ctrl #(
   parameter int unsigned ADDR_LMT    = 20,
   parameter int unsigned MDATA       = 14,
   parameter int unsigned CACHE_WIDTH = 512,
   parameter int unsigned DATA_WIDTH  = 32,
   parameter int unsigned LEN_W       = 24
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic [ADDR_LMT+3:0]     base_addr,
   input  logic [LEN_W-1:0]        num_words,
   input  logic [DATA_WIDTH-1:0]   in_data,
   input  logic                    in_valid,
   output logic                    in_ready,
   output logic                    wr_en,
   output logic                    wr_now,
   output logic [ADDR_LMT+3:0]     wr_addr,
   output logic [CACHE_WIDTH-1:0]  wr_data,
   output logic [MDATA-1:0]        wr_mdata,
   output logic                    wr_direct,
   input  logic                    wr_req_almostfull,
   input  logic                    wr_real_valid,
   output logic                    busy,
`ifdef RESULT_WR_PERF_EN
   output logic [31:0]             perf_cycles,
   output logic [31:0]             stall_cycles,
`endif
   output logic                    done
);

   localparam int unsigned AW = ADDR_LMT + 4;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      RUN      = 3'd1,
      BUBBLE   = 3'd2,
      WAIT_RSP = 3'd3,
      DONE     = 3'd4
   } state_t;

   state_t            state;
   logic [AW-1:0]     cur_addr;
   logic [LEN_W-1:0]  remaining;
   logic [LEN_W-1:0]  line_cnt;
   logic [LEN_W-1:0]  rsp_cnt;
   logic              last_line;
   logic              hs;
   logic              closing;
   logic              rsp_window;

   // Stream accepted only in RUN and only while the write channel has room.
   assign in_ready   = (state == RUN) && !wr_req_almostfull;
   assign hs         = in_valid && in_ready;
   // A word closes its line at offset 15 or when it is the last of the job.
   assign closing    = (cur_addr[3:0] == 4'hF) || (remaining == LEN_W'(1));
   // Responses may arrive any time after the first flush, before WAIT_RSP too.
   assign rsp_window = (state == RUN) || (state == BUBBLE) || (state == WAIT_RSP);
   assign wr_direct  = 1'b0;

   // Job FSM with registered write-port outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cur_addr  <= '0;
         remaining <= '0;
         line_cnt  <= '0;
         rsp_cnt   <= '0;
         last_line <= 1'b0;
         wr_en     <= 1'b0;
         wr_now    <= 1'b0;
         wr_addr   <= '0;
         wr_data   <= '0;
         wr_mdata  <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         wr_en  <= 1'b0;
         wr_now <= 1'b0;
         done   <= 1'b0;

         if (wr_real_valid && rsp_window) begin
            rsp_cnt <= rsp_cnt + LEN_W'(1);
         end

         case (state)
            IDLE: begin
               if (start) begin
                  cur_addr  <= base_addr;
                  remaining <= num_words;
                  busy      <= 1'b1;
                  state     <= (num_words == '0) ? DONE : RUN;
               end
            end

            RUN: begin
               if (hs) begin
                  wr_en     <= 1'b1;
                  wr_now    <= closing;
                  wr_addr   <= cur_addr;
                  wr_data   <= CACHE_WIDTH'(in_data);
                  wr_mdata  <= MDATA'(line_cnt);
                  cur_addr  <= cur_addr + AW'(1);
                  remaining <= remaining - LEN_W'(1);
                  if (closing) begin
                     line_cnt  <= line_cnt + LEN_W'(1);
                     last_line <= (remaining == LEN_W'(1));
                     state     <= BUBBLE;
                  end
               end
            end

            // One dead cycle after each flush gives the buffer its issue slot.
            BUBBLE: begin
               state <= last_line ? WAIT_RSP : RUN;
            end

            WAIT_RSP: begin
               if (rsp_cnt == line_cnt) begin
                  state <= DONE;
               end
            end

            DONE: begin
               done      <= 1'b1;
               busy      <= 1'b0;
               line_cnt  <= '0;
               rsp_cnt   <= '0;
               last_line <= 1'b0;
               state     <= IDLE;
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

`ifdef RESULT_WR_PERF_EN
   // Job duration and input-stall counters; values hold until the next start.
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_cycles  <= '0;
         stall_cycles <= '0;
      end else if (state == IDLE) begin
         if (start) begin
            perf_cycles  <= 32'd1;
            stall_cycles <= '0;
         end
      end else begin
         if (perf_cycles != '1) begin
            perf_cycles <= perf_cycles + 32'd1;
         end
         if ((state == RUN) && in_valid && !in_ready && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_result_wr_ctrl.sv
// Self-checking bench for result_wr_ctrl: directed jobs, a queue-based model of
// the expected write sequence, a per-cycle compare process and a response
// generator that answers every flushed line five cycles later.
module tb_result_wr_ctrl;

   localparam int unsigned AW = 24;
   localparam int unsigned LW = 24;
   localparam int unsigned MD = 14;
   localparam int unsigned CW = 512;
   localparam int unsigned DW = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [AW-1:0] base_addr;
   logic [LW-1:0] num_words;
   logic [DW-1:0] in_data;
   logic          in_valid;
   logic          in_ready;
   logic          wr_en;
   logic          wr_now;
   logic [AW-1:0] wr_addr;
   logic [CW-1:0] wr_data;
   logic [MD-1:0] wr_mdata;
   logic          wr_direct;
   logic          wr_req_almostfull;
   logic          wr_real_valid;
   logic          busy;
   logic          done;
`ifdef RESULT_WR_PERF_EN
   logic [31:0]   perf_cycles;
   logic [31:0]   stall_cycles;
`endif

   always #5 clk = ~clk;

   result_wr_ctrl dut (
      .clk               (clk),
      .rst               (rst),
      .start             (start),
      .base_addr         (base_addr),
      .num_words         (num_words),
      .in_data           (in_data),
      .in_valid          (in_valid),
      .in_ready          (in_ready),
      .wr_en             (wr_en),
      .wr_now            (wr_now),
      .wr_addr           (wr_addr),
      .wr_data           (wr_data),
      .wr_mdata          (wr_mdata),
      .wr_direct         (wr_direct),
      .wr_req_almostfull (wr_req_almostfull),
      .wr_real_valid     (wr_real_valid),
      .busy              (busy),
`ifdef RESULT_WR_PERF_EN
      .perf_cycles       (perf_cycles),
      .stall_cycles      (stall_cycles),
`endif
      .done              (done)
   );

   typedef struct {
      logic [AW-1:0] addr;
      logic [31:0]   data;
      logic          now;
      logic [MD-1:0] mdata;
   } exp_t;

   exp_t          exp_q[$];
   exp_t          cmp_e;
   int            resp_due[$];
   logic [AW-1:0] now_addr[$];
   logic [MD-1:0] now_mdata[$];

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int n_wr  = 0;
   int n_done = 0;
   int rsp_given = 0;
   int exp_lines = 0;
   int done_cyc = 0;
   int start_cyc = 0;
   int wr0, done0, rsp0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Model: word i goes to base+i (wrapping); a line closes at offset 15 or on
   // the final word, and each word carries the count of lines closed before it.
   task automatic build_model(input logic [AW-1:0] base, input int num, input int seed);
      exp_t e;
      int   line;
      line = 0;
      exp_q.delete();
      for (int i = 0; i < num; i++) begin
         e.addr  = base + AW'(i);
         e.data  = 32'(seed + i);
         e.now   = (e.addr[3:0] == 4'hF) || (i == num - 1);
         e.mdata = MD'(line);
         exp_q.push_back(e);
         if (e.now) line++;
      end
      exp_lines = line;
   endtask

   // Response generator: one wr_real_valid per flushed line, five cycles later.
   always @(negedge clk) begin
      if (rst) begin
         resp_due.delete();
         wr_real_valid = 1'b0;
      end else if (resp_due.size() != 0 && resp_due[0] <= cyc) begin
         void'(resp_due.pop_front());
         wr_real_valid = 1'b1;
         rsp_given++;
      end else begin
         wr_real_valid = 1'b0;
      end
   end

   // Per-cycle comparison of DUT outputs against the model.
   always @(negedge clk) begin
      #2;
      if (wr_req_almostfull) check("ready_low_af", 64'(in_ready), 64'd0);
      if (wr_en) begin
         check("expected_pending", 64'(exp_q.size() != 0), 64'd1);
         if (exp_q.size() != 0) begin
            cmp_e = exp_q.pop_front();
            check("wr_addr", 64'(wr_addr), 64'(cmp_e.addr));
            check("wr_data", 64'(wr_data[31:0]), 64'(cmp_e.data));
            check("wr_data_upper_zero", 64'(|wr_data[CW-1:32]), 64'd0);
            check("wr_now", 64'(wr_now), 64'(cmp_e.now));
            check("wr_mdata", 64'(wr_mdata), 64'(cmp_e.mdata));
            check("wr_direct", 64'(wr_direct), 64'd0);
            n_wr++;
            if (wr_now) begin
               now_addr.push_back(wr_addr);
               now_mdata.push_back(wr_mdata);
               resp_due.push_back(cyc + 5);
            end
         end
      end else begin
         check("now_without_en", 64'(wr_now), 64'd0);
      end
      if (done) begin
         n_done++;
         done_cyc = cyc;
         check("done_all_rsp", 64'(rsp_given - rsp0), 64'(exp_lines));
         check("done_queue_empty", 64'(exp_q.size()), 64'd0);
         check("busy_at_done", 64'(busy), 64'd0);
      end
   end

   // Launch a job and stream its words; af_lo..af_hi are RUN-cycle indices with
   // almostfull high; rst_after>=0 resets the DUT after that many words.
   task automatic run_job(input logic [AW-1:0] base, input int num, input int seed,
                          input int af_lo, input int af_hi, input int rst_after);
      int sent;
      int r;
      build_model(base, num, seed);
      now_addr.delete();
      now_mdata.delete();
      wr0   = n_wr;
      done0 = n_done;
      rsp0  = rsp_given;
      @(negedge clk);
      start     = 1'b1;
      base_addr = base;
      num_words = LW'(num);
      start_cyc = cyc;
      @(negedge clk);
      start = 1'b0;
      #1 check("busy_after_start", 64'(busy), 64'd1);
      sent = 0;
      r = 0;
      while (sent < num && r < 500 && !(rst_after >= 0 && sent >= rst_after)) begin
         wr_req_almostfull = (r >= af_lo) && (r <= af_hi);
         in_valid = 1'b1;
         in_data  = 32'(seed + sent);
         #1;
         if (in_ready) sent++;
         @(negedge clk);
         r++;
      end
      in_valid = 1'b0;
      wr_req_almostfull = 1'b0;
      check("feed_in_budget", 64'(r < 500), 64'd1);
      if (rst_after >= 0) begin
         rst = 1'b1;
         @(negedge clk);
         #1;
         check("rst_wr_en", 64'(wr_en), 64'd0);
         check("rst_wr_now", 64'(wr_now), 64'd0);
         check("rst_wr_addr", 64'(wr_addr), 64'd0);
         check("rst_wr_mdata", 64'(wr_mdata), 64'd0);
         check("rst_busy", 64'(busy), 64'd0);
         check("rst_done", 64'(done), 64'd0);
         check("rst_in_ready", 64'(in_ready), 64'd0);
         @(negedge clk);
         rst = 1'b0;
         exp_q.delete();
         repeat (20) @(negedge clk);
         check("rst_no_done", 64'(n_done - done0), 64'd0);
      end else begin
         for (int w = 0; w < 200 && n_done == done0; w++) begin
            @(negedge clk);
            #3;
         end
         check("done_seen", 64'(n_done != done0), 64'd1);
         repeat (8) @(negedge clk);
         check("done_once", 64'(n_done - done0), 64'd1);
      end
   endtask

   initial begin
      rst = 1'b1;
      start = 1'b0;
      base_addr = '0;
      num_words = '0;
      in_data = '0;
      in_valid = 1'b0;
      wr_req_almostfull = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      check("reset_wr_en", 64'(wr_en), 64'd0);
      check("reset_busy", 64'(busy), 64'd0);
      check("reset_done", 64'(done), 64'd0);
      check("reset_in_ready", 64'(in_ready), 64'd0);
      check("reset_wr_addr", 64'(wr_addr), 64'd0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // Aligned full line, data 1..16.
      run_job(24'h000040, 16, 1, -1, -1, -1);
      check("aligned_wr_count", 64'(n_wr - wr0), 64'd16);
      check("aligned_now_count", 64'(now_addr.size()), 64'd1);
      if (now_addr.size() >= 1) check("aligned_now_addr", 64'(now_addr[0]), 64'h4F);
      check("aligned_rsp", 64'(rsp_given - rsp0), 64'd1);
      check("aligned_latency", 64'(done_cyc - start_cyc), 64'd25);

      // Partial tail crossing a line boundary.
      run_job(24'h00004E, 5, 100, -1, -1, -1);
      check("partial_now_count", 64'(now_addr.size()), 64'd2);
      if (now_addr.size() >= 2) begin
         check("partial_now0_addr", 64'(now_addr[0]), 64'h4F);
         check("partial_now1_addr", 64'(now_addr[1]), 64'h52);
         check("partial_now0_mdata", 64'(now_mdata[0]), 64'd0);
         check("partial_now1_mdata", 64'(now_mdata[1]), 64'd1);
      end
      check("partial_rsp", 64'(rsp_given - rsp0), 64'd2);

      // Zero-length job.
      run_job(24'h000080, 0, 0, -1, -1, -1);
      check("zero_wr_count", 64'(n_wr - wr0), 64'd0);
      check("zero_latency", 64'(done_cyc - start_cyc), 64'd2);

      // Backpressure in RUN cycles 3..6.
      run_job(24'h000100, 8, 200, 3, 6, -1);
      check("bp_wr_count", 64'(n_wr - wr0), 64'd8);
      check("bp_latency", 64'(done_cyc - start_cyc), 64'd21);
`ifdef RESULT_WR_PERF_EN
      check("perf_cycles", 64'(perf_cycles), 64'(done_cyc - start_cyc));
      check("stall_cycles", 64'(stall_cycles), 64'd4);
`endif

      // Address wrap past the top of the word space.
      run_job(24'hFFFFFE, 4, 300, -1, -1, -1);
      check("wrap_now_count", 64'(now_addr.size()), 64'd2);
      if (now_addr.size() >= 2) begin
         check("wrap_now0_addr", 64'(now_addr[0]), 64'hFFFFFF);
         check("wrap_now1_addr", 64'(now_addr[1]), 64'h000001);
      end

      // Reset mid-job after 10 of 32 words (one line already flushed).
      run_job(24'h000208, 32, 400, -1, -1, 10);

      // A fresh job after the reset restarts tags at 0.
      run_job(24'h00004E, 5, 500, -1, -1, -1);
      if (now_mdata.size() >= 1) check("post_rst_mdata", 64'(now_mdata[0]), 64'd0);
      check("post_rst_wr_count", 64'(n_wr - wr0), 64'd5);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: got cycle %0d want finish", cyc);
      $fatal(1, "timeout");
   end

endmodule
